// File: rtl/shot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shot_sequencer
// Purpose  : Turns fire requests into scorer transactions. Coordinates and
//            big-bomb availability are checked locally. Each valid shot is
//            issued to the scorer for one cycle. Scorer results are latched,
//            and the shot and hit counters are kept up to date.
// Options  : SHOT_SEQUENCER_DUP_CHECK_EN - keep a 100-cell fired bitmap and
//            refuse small shots at a cell that has already been fired at.
// Revision : 1.0 - initial release
// ============================================================================
module shot_sequencer #(
  parameter int MAX_SHOTS          = 30,
  parameter int TOTAL_SHIP_SQUARES = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       fire,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic       big_req,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       big,
  output logic [1:0] bigLeft,
  output logic       scoreThis,
  input  logic       isHit,
  input  logic       isNearMiss,
  input  logic       isMiss,
  input  logic [4:0] biggestShip,
  input  logic [3:0] numHit,
  input  logic       somethingWrong,
  output logic       last_hit,
  output logic       last_near,
  output logic       last_miss,
  output logic [4:0] last_ship,
  output logic [5:0] shots_fired,
  output logic [4:0] hits_total,
  output logic       reject,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] X_q, X_d, Y_q, Y_d;
  logic       big_q, big_d;
  logic [1:0] bigLeft_q, bigLeft_d;
  logic       reject_q, reject_d;
  logic       last_hit_q, last_hit_d;
  logic       last_near_q, last_near_d;
  logic       last_miss_q, last_miss_d;
  logic [4:0] last_ship_q, last_ship_d;
  logic [5:0] shots_q, shots_d;
  logic [4:0] hits_q, hits_d;

  // Local legality of the requested shot
  logic       w_coord_ok;
  logic       w_no_big;
  logic       w_dup;
  logic       w_bad;
  // Saturating hit accumulation for the shot under issue
  logic [5:0] w_hits_sum;
  logic [4:0] w_hits_sat;
  logic [5:0] w_shots_inc;

  assign w_coord_ok = (x_in >= 4'd1) && (x_in <= 4'd10) &&
                      (y_in >= 4'd1) && (y_in <= 4'd10);
  assign w_no_big   = big_req && (bigLeft_q == 2'd0);

`ifdef SHOT_SEQUENCER_DUP_CHECK_EN
  // Cell (x,y) lives at bit (y-1)*10 + (x-1)
  logic [99:0] fired_q, fired_d;
  logic [6:0]  w_cell_idx;
  logic [4:0]  cx, cy;
  logic [4:0]  w_x5, w_y5;
  logic        dx_ok, dy_ok;

  assign w_cell_idx = (({3'b000, y_in} - 7'd1) * 7'd10) + {3'b000, x_in} - 7'd1;
  // Only small shots are refused on a repeat; big bombs may overlap.
  assign w_dup      = w_coord_ok && !big_req && fired_q[w_cell_idx];
  assign w_x5       = {1'b0, X_q};
  assign w_y5       = {1'b0, Y_q};

  // Fired bitmap: cleared on a new game, marked by each accepted shot
  always_comb begin
    fired_d = fired_q;
    cx      = 5'd0;
    cy      = 5'd0;
    dx_ok   = 1'b0;
    dy_ok   = 1'b0;
    if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      fired_d = '0;
    end else if (state_q == S_ISSUE && !somethingWrong) begin
      for (int i = 0; i < 100; i++) begin
        cx    = 5'(i % 10 + 1);
        cy    = 5'(i / 10 + 1);
        dx_ok = big_q ? ((cx + 5'd1 >= w_x5) && (cx <= w_x5 + 5'd1)) : (cx == w_x5);
        dy_ok = big_q ? ((cy + 5'd1 >= w_y5) && (cy <= w_y5 + 5'd1)) : (cy == w_y5);
        if (dx_ok && dy_ok) begin
          fired_d[i[6:0]] = 1'b1;
        end
      end
    end
  end

  // Bitmap register
  always_ff @(posedge clock) begin
    if (reset) begin
      fired_q <= '0;
    end else begin
      fired_q <= fired_d;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_bad       = !w_coord_ok || w_no_big || w_dup;
  assign w_hits_sum  = {1'b0, hits_q} + {2'b00, numHit};
  assign w_hits_sat  = (w_hits_sum >= 6'(TOTAL_SHIP_SQUARES)) ?
                       5'(TOTAL_SHIP_SQUARES) : w_hits_sum[4:0];
  assign w_shots_inc = shots_q + 6'd1;

  // Next-state and datapath updates for the game sequencer
  always_comb begin
    state_d     = state_q;
    X_d         = X_q;
    Y_d         = Y_q;
    big_d       = big_q;
    bigLeft_d   = bigLeft_q;
    reject_d    = 1'b0;
    last_hit_d  = last_hit_q;
    last_near_d = last_near_q;
    last_miss_d = last_miss_q;
    last_ship_d = last_ship_q;
    shots_d     = shots_q;
    hits_d      = hits_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // start outranks a coincident fire, which is simply dropped
        if (start) begin
          bigLeft_d   = 2'd2;
          last_hit_d  = 1'b0;
          last_near_d = 1'b0;
          last_miss_d = 1'b0;
          last_ship_d = 5'd0;
          shots_d     = 6'd0;
          hits_d      = 5'd0;
          state_d     = S_ARMED;
        end
      end
      S_ARMED: begin
        if (fire) begin
          if (w_bad) begin
            reject_d = 1'b1;
          end else begin
            X_d     = x_in;
            Y_d     = y_in;
            big_d   = big_req;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (somethingWrong) begin
          reject_d = 1'b1;
          state_d  = S_ARMED;
        end else begin
          last_hit_d  = isHit;
          last_near_d = isNearMiss;
          last_miss_d = isMiss;
          last_ship_d = biggestShip;
          shots_d     = w_shots_inc;
          hits_d      = w_hits_sat;
          if (big_q && bigLeft_q != 2'd0) begin
            bigLeft_d = bigLeft_q - 2'd1;
          end
          if (w_hits_sat == 5'(TOTAL_SHIP_SQUARES) || w_shots_inc == 6'(MAX_SHOTS)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      X_q         <= 4'd0;
      Y_q         <= 4'd0;
      big_q       <= 1'b0;
      bigLeft_q   <= 2'd0;
      reject_q    <= 1'b0;
      last_hit_q  <= 1'b0;
      last_near_q <= 1'b0;
      last_miss_q <= 1'b0;
      last_ship_q <= 5'd0;
      shots_q     <= 6'd0;
      hits_q      <= 5'd0;
    end else begin
      state_q     <= state_d;
      X_q         <= X_d;
      Y_q         <= Y_d;
      big_q       <= big_d;
      bigLeft_q   <= bigLeft_d;
      reject_q    <= reject_d;
      last_hit_q  <= last_hit_d;
      last_near_q <= last_near_d;
      last_miss_q <= last_miss_d;
      last_ship_q <= last_ship_d;
      shots_q     <= shots_d;
      hits_q      <= hits_d;
    end
  end

  assign X           = X_q;
  assign Y           = Y_q;
  assign big         = big_q;
  assign bigLeft     = bigLeft_q;
  assign scoreThis   = (state_q == S_ISSUE);
  assign last_hit    = last_hit_q;
  assign last_near   = last_near_q;
  assign last_miss   = last_miss_q;
  assign last_ship   = last_ship_q;
  assign shots_fired = shots_q;
  assign hits_total  = hits_q;
  assign reject      = reject_q;
  assign game_over   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shot_sequencer
// Purpose  : Self-checking bench for shot_sequencer (default parameters).
//            Honours SHOT_SEQUENCER_DUP_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shot_sequencer;

`ifdef SHOT_SEQUENCER_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, start, fire, big_req;
  logic [3:0] x_in, y_in;
  logic [3:0] X, Y;
  logic       big, scoreThis;
  logic [1:0] bigLeft;
  logic       isHit, isNearMiss, isMiss, somethingWrong;
  logic [4:0] biggestShip;
  logic [3:0] numHit;
  logic       last_hit, last_near, last_miss;
  logic [4:0] last_ship;
  logic [5:0] shots_fired;
  logic [4:0] hits_total;
  logic       reject, game_over;

  shot_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .fire(fire),
    .x_in(x_in), .y_in(y_in), .big_req(big_req),
    .X(X), .Y(Y), .big(big), .bigLeft(bigLeft), .scoreThis(scoreThis),
    .isHit(isHit), .isNearMiss(isNearMiss), .isMiss(isMiss),
    .biggestShip(biggestShip), .numHit(numHit), .somethingWrong(somethingWrong),
    .last_hit(last_hit), .last_near(last_near), .last_miss(last_miss),
    .last_ship(last_ship), .shots_fired(shots_fired), .hits_total(hits_total),
    .reject(reject), .game_over(game_over)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // kind: 0 local reject, 1 scorer reject, 2 accepted, 3 ignored
  typedef struct {
    logic [3:0] x, y;
    logic       b;
    logic [2:0] resp;   // {hit, near, miss}
    logic [4:0] ship;
    logic [3:0] nh;
    logic       sw;
    int         kind;
    int         e_shots, e_hits, e_bl;
    logic [2:0] e_last;
    logic [4:0] e_ship;
    logic       e_go;
  } vec_t;

  typedef struct packed {
    logic [3:0] x, y;
    logic       b;
  } iss_t;

  iss_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int x, y, b, resp, ship, nh, sw, kind,
                              input int es, eh, ebl, elast, eship, ego);
    vec_t v;
    v.x = 4'(x); v.y = 4'(y); v.b = 1'(b); v.resp = 3'(resp);
    v.ship = 5'(ship); v.nh = 4'(nh); v.sw = 1'(sw); v.kind = kind;
    v.e_shots = es; v.e_hits = eh; v.e_bl = ebl;
    v.e_last = 3'(elast); v.e_ship = 5'(eship); v.e_go = 1'(ego);
    return v;
  endfunction

  // Every issued shot must match the oldest expected issue record
  always @(negedge clock) begin
    if (scoreThis) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_scoreThis", 1, 0);
      end else begin
        iss_t e;
        e = sb_q.pop_front();
        chk("issue_X", X, e.x);
        chk("issue_Y", Y, e.y);
        chk("issue_big", big, e.b);
      end
    end
  end

  task automatic do_shot(input string tag, input vec_t v);
    @(negedge clock);
    x_in = v.x; y_in = v.y; big_req = v.b;
    {isHit, isNearMiss, isMiss} = v.resp;
    biggestShip = v.ship; numHit = v.nh; somethingWrong = v.sw;
    fire = 1'b1;
    if (v.kind == 1 || v.kind == 2) sb_q.push_back('{x: v.x, y: v.y, b: v.b});
    @(negedge clock);
    fire = 1'b0;
    chk({tag, "_reject_t1"}, reject, int'(v.kind == 0));
    chk({tag, "_score_t1"}, scoreThis, int'(v.kind == 1 || v.kind == 2));
    @(negedge clock);
    chk({tag, "_reject_t2"}, reject, int'(v.kind == 1));
    chk({tag, "_score_t2"}, scoreThis, 0);
    chk({tag, "_shots"}, shots_fired, v.e_shots);
    chk({tag, "_hits"}, hits_total, v.e_hits);
    chk({tag, "_bigLeft"}, bigLeft, v.e_bl);
    chk({tag, "_last"}, {last_hit, last_near, last_miss}, v.e_last);
    chk({tag, "_ship"}, last_ship, v.e_ship);
    chk({tag, "_game_over"}, game_over, v.e_go);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    int s;
    vec_t v;
    reset = 1'b1; start = 1'b0; fire = 1'b0; big_req = 1'b0;
    x_in = 4'd0; y_in = 4'd0; isHit = 1'b0; isNearMiss = 1'b0; isMiss = 1'b0;
    biggestShip = 5'd0; numHit = 4'd0; somethingWrong = 1'b0;

    // Game 1 table: {x,y,big,resp,ship,nh,sw,kind, shots,hits,bigLeft,last,ship,go}
    vecs[0]  = mk(7, 6, 0, 3'b100, 1, 1, 0, 2,   1, 1, 2, 3'b100, 1, 0);
    vecs[1]  = mk(0, 5, 0, 3'b100, 1, 1, 0, 0,   1, 1, 2, 3'b100, 1, 0);
    vecs[2]  = mk(11, 3, 0, 3'b100, 1, 1, 0, 0,  1, 1, 2, 3'b100, 1, 0);
    vecs[3]  = mk(2, 2, 1, 3'b010, 0, 0, 0, 2,   2, 1, 1, 3'b010, 0, 0);
    vecs[4]  = mk(5, 5, 0, 3'b100, 2, 1, 1, 1,   2, 1, 1, 3'b010, 0, 0);
    vecs[5]  = mk(9, 9, 1, 3'b100, 2, 1, 1, 1,   2, 1, 1, 3'b010, 0, 0);
    vecs[6]  = mk(8, 2, 1, 3'b100, 4, 3, 0, 2,   3, 4, 0, 3'b100, 4, 0);
    vecs[7]  = mk(4, 8, 1, 3'b100, 0, 0, 0, 0,   3, 4, 0, 3'b100, 4, 0);
    vecs[8]  = mk(1, 10, 0, 3'b001, 0, 0, 0, 2,  4, 4, 0, 3'b001, 0, 0);
    vecs[9]  = mk(10, 1, 0, 3'b100, 16, 13, 0, 2, 5, 17, 0, 3'b100, 16, 0);
    vecs[10] = mk(3, 0, 0, 3'b100, 1, 1, 0, 0,   5, 17, 0, 3'b100, 16, 0);
    vecs[11] = mk(15, 15, 0, 3'b100, 1, 1, 0, 0, 5, 17, 0, 3'b100, 16, 0);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_X", X, 0);
    chk("rst_Y", Y, 0);
    chk("rst_bigLeft", bigLeft, 0);
    chk("rst_score", scoreThis, 0);
    chk("rst_counters", {shots_fired, hits_total}, 0);
    chk("rst_last", {last_hit, last_near, last_miss, last_ship}, 0);
    chk("rst_flags", {reject, game_over}, 0);

    // fire in IDLE is ignored
    do_shot("idle_fire", mk(4, 4, 0, 3'b100, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0));

    pulse_start();
    chk("start_bigLeft", bigLeft, 2);
    for (int i = 0; i < 12; i++) do_shot($sformatf("v%0d", i), vecs[i]);

    // start while ARMED is ignored
    pulse_start();
    chk("armed_start_shots", shots_fired, 5);
    chk("armed_start_hits", hits_total, 17);

    // Game 2: saturate hits to end the game with a big bomb
    do_reset();
    pulse_start();
    do_shot("g2a", mk(1, 1, 0, 3'b100, 1, 15, 0, 2, 1, 15, 2, 3'b100, 1, 0));
    do_shot("g2b", mk(2, 1, 0, 3'b100, 2, 2, 0, 2,  2, 17, 2, 3'b100, 2, 0));
    do_shot("g2c", mk(5, 5, 1, 3'b100, 8, 4, 0, 2,  3, 19, 1, 3'b100, 8, 1));
    do_shot("g2_done_fire", mk(3, 3, 0, 3'b100, 1, 1, 0, 3, 3, 19, 1, 3'b100, 8, 1));
    pulse_start();
    chk("restart_go", game_over, 0);
    chk("restart_counters", {shots_fired, hits_total}, 0);
    chk("restart_bigLeft", bigLeft, 2);
    chk("restart_last", {last_hit, last_near, last_miss, last_ship}, 0);

    // Game 3: the shot limit ends the game
    for (int i = 0; i < 30; i++) begin
      do_shot($sformatf("lim%0d", i),
              mk(i % 10 + 1, i / 10 + 1, 0, 3'b001, 0, 0, 0, 2,
                 i + 1, 0, 2, 3'b001, 0, int'(i == 29)));
    end

    // Game 4: repeated cells
    pulse_start();
    s = 1;
    do_shot("dup_a", mk(3, 3, 0, 3'b001, 0, 0, 0, 2, s, 0, 2, 3'b001, 0, 0));
    s = DUP ? s : s + 1;
    do_shot("dup_b", mk(3, 3, 0, 3'b001, 0, 0, 0, DUP ? 0 : 2, s, 0, 2, 3'b001, 0, 0));
    s = s + 1;
    do_shot("dup_c", mk(6, 6, 1, 3'b001, 0, 0, 0, 2, s, 0, 1, 3'b001, 0, 0));
    s = DUP ? s : s + 1;
    do_shot("dup_d", mk(7, 7, 0, 3'b001, 0, 0, 0, DUP ? 0 : 2, s, 0, 1, 3'b001, 0, 0));
    s = s + 1;
    do_shot("dup_e", mk(7, 8, 0, 3'b001, 0, 0, 0, 2, s, 0, 1, 3'b001, 0, 0));

    // Reset while a shot is under issue aborts it
    @(negedge clock);
    x_in = 4'd9; y_in = 4'd10; big_req = 1'b0; fire = 1'b1;
    {isHit, isNearMiss, isMiss} = 3'b100; numHit = 4'd1; somethingWrong = 1'b0;
    sb_q.push_back('{x: 4'd9, y: 4'd10, b: 1'b0});
    @(negedge clock);
    fire = 1'b0;
    chk("abort_score", scoreThis, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_shots", shots_fired, 0);
    chk("abort_hits", hits_total, 0);
    chk("abort_X", X, 0);
    chk("abort_score_after", scoreThis, 0);

    // start and fire together in IDLE: start wins
    @(negedge clock);
    start = 1'b1; fire = 1'b1; x_in = 4'd4; y_in = 4'd4;
    @(negedge clock);
    start = 1'b0; fire = 1'b0;
    chk("sf_score", scoreThis, 0);
    chk("sf_bigLeft", bigLeft, 2);
    @(negedge clock);
    chk("sf_shots", shots_fired, 0);
    chk("sf_score2", scoreThis, 0);

    repeat (2) @(negedge clock);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
